// File: rtl/uart_rx.sv
// Serial receiver for one-bit-per-clock frames (start 0, data MSB first, stop 1)
// feeding a small FIFO, with sticky framing-error and overrun flags.
module uart_rx #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic       rx,
  input  logic       clear_err,
  input  logic       O_ready,
  output logic [7:0] O_data,
  output logic       O_valid,
  output logic       frame_err,
  output logic       overrun
);

  // state | meaning
  // IDLE  | line idle, waiting for a 0 start bit
  // DATA  | sampling data bits 7..0 into shift, idx counts down
  // STOP  | checking stop bit; push byte on 1, flag frame error on 0
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        push_req, ferr_set;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, push_ok, ovr_set;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
      idx   <= 3'd7;
      shift <= 8'h00;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shift_nxt = shift;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          state_nxt = DATA;
          idx_nxt   = 3'd7;
        end
      end
      DATA: begin
        shift_nxt[idx] = rx;
        idx_nxt        = idx - 3'd1;
        if (idx == 3'd0) state_nxt = STOP;
      end
      STOP: begin
        // a low stop bit is never reinterpreted as the next start bit
        if (rx) push_req = 1'b1;
        else    ferr_set = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign O_valid = !empty;
  assign O_data  = mem[rd_ptr[AW-1:0]];
  assign pop     = O_valid && O_ready;
  // a same-cycle pop frees the slot, so a full FIFO still accepts the byte
  assign push_ok = push_req && (!full || pop);
  assign ovr_set = push_req && full && !pop;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)       frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (ovr_set)        overrun   <= 1'b1;
      else if (clear_err) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a queue-based byte FIFO model is
// updated from the frames driven, and a monitor compares every cycle.
module tb_uart_rx;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic       rx;
  logic       clear_err;
  logic       O_ready;
  logic [7:0] O_data;
  logic       O_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .rx         (rx),
    .clear_err  (clear_err),
    .O_ready    (O_ready),
    .O_data     (O_data),
    .O_valid    (O_valid),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr  = 1'b0;
  logic       pend_push = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  logic       pend_ferr = 1'b0;
  logic       in_reset  = 1'b1;
  int         rdy_mode  = 0;   // 0 low, 1 high, 2 random
  bit         stop_ready = 1'b0;
  bit         clr_rand   = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_chk();
    chk("rst_valid", 8'(O_valid), 8'h00);
    chk("rst_data", O_data, 8'h00);
    chk("rst_frame_err", 8'(frame_err), 8'h00);
    chk("rst_overrun", 8'(overrun), 8'h00);
  endtask

  // kind: 0 plain bit, 1 good stop (byte b pushed), 2 bad stop
  task automatic cycle(input logic rx_v, input int kind, input logic [7:0] b, input bit clr);
    @(negedge CLK);
    rx = rx_v;
    case (rdy_mode)
      0:       O_ready = 1'b0;
      1:       O_ready = 1'b1;
      default: O_ready = 1'($urandom_range(0, 1));
    endcase
    if (kind != 0 && stop_ready) O_ready = 1'b1;
    clear_err = clr || (clr_rand && ($urandom_range(0, 7) == 0));
    if (kind == 1) begin
      pend_push = 1'b1;
      pend_byte = b;
    end
    if (kind == 2) pend_ferr = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    cycle(1'b0, 0, 8'h00, 1'b0);
    for (int i = 7; i >= 0; i--) cycle(b[i], 0, 8'h00, 1'b0);
    cycle(good, good ? 1 : 2, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 0, 8'h00, 1'b0);
  endtask

  // Monitor: compare DUT against the model, then apply this cycle's events.
  initial begin
    logic ovr_ev;
    forever begin
      @(negedge CLK);
      #2;
      if (!in_reset) begin
        chk("valid", 8'(O_valid), 8'(mq.size() != 0));
        if (mq.size() != 0) chk("data", O_data, mq[0]);
        chk("frame_err", 8'(frame_err), 8'(exp_ferr));
        chk("overrun", 8'(overrun), 8'(exp_ovr));
        if (O_ready && mq.size() != 0) void'(mq.pop_front());
        ovr_ev = 1'b0;
        if (pend_push) begin
          if (mq.size() < DEPTH) mq.push_back(pend_byte);
          else ovr_ev = 1'b1;
        end
        if (clear_err) begin
          exp_ferr = 1'b0;
          exp_ovr  = 1'b0;
        end
        if (pend_ferr) exp_ferr = 1'b1;
        if (ovr_ev) exp_ovr = 1'b1;
        pend_push = 1'b0;
        pend_ferr = 1'b0;
      end
    end
  end

  initial begin
    ASYNCRESETN = 1'b0;
    rx = 1'b1;
    clear_err = 1'b0;
    O_ready = 1'b0;
    #3;
    reset_chk();
    repeat (2) @(negedge CLK);
    ASYNCRESETN = 1'b1;
    in_reset = 1'b0;

    // single frame, visible one cycle after the stop edge
    rdy_mode = 0;
    send_frame(8'hA5, 1'b1);
    idle(2);
    rdy_mode = 1;
    idle(2);

    // back-to-back frames held in the FIFO
    rdy_mode = 0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(3);
    rdy_mode = 1;
    idle(3);

    // framing error, then a good frame, then clear
    send_frame(8'h3C, 1'b0);
    send_frame(8'h11, 1'b1);
    idle(3);
    cycle(1'b1, 0, 8'h00, 1'b1);
    idle(2);

    // overrun: DEPTH+1 frames with no consumer
    rdy_mode = 0;
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b1);
    idle(2);
    rdy_mode = 1;
    idle(DEPTH + 2);
    cycle(1'b1, 0, 8'h00, 1'b1);
    idle(1);

    // full FIFO with a pop on the stop cycle
    rdy_mode = 0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h60 + 8'(i), 1'b1);
    stop_ready = 1'b1;
    send_frame(8'h77, 1'b1);
    stop_ready = 1'b0;
    idle(2);
    rdy_mode = 1;
    idle(DEPTH + 2);

    // reset in the middle of a frame with a byte buffered
    rdy_mode = 0;
    send_frame(8'h5A, 1'b1);
    cycle(1'b0, 0, 8'h00, 1'b0);
    for (int i = 7; i >= 4; i--) cycle(1'(8'hC3 >> i), 0, 8'h00, 1'b0);
    #3;
    in_reset = 1'b1;
    ASYNCRESETN = 1'b0;
    #1;
    reset_chk();
    mq.delete();
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    pend_push = 1'b0;
    pend_ferr = 1'b0;
    idle(3);
    @(negedge CLK);
    rx = 1'b1;
    ASYNCRESETN = 1'b1;
    in_reset = 1'b0;
    rdy_mode = 1;
    send_frame(8'h42, 1'b1);
    idle(3);

    // randomized traffic
    rdy_mode = 2;
    clr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
      idle(int'($urandom_range(0, 2)));
    end
    clr_rand = 1'b0;
    rdy_mode = 1;
    idle(2 * DEPTH + 4);
    @(negedge CLK);
    #3;
    chk("drained", 8'(O_valid), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DEPTH, default 4, depth of the received-byte FIFO; legal values are powers of two from 2 to 16.
REQ-002 Port: CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: ASYNCRESETN  input  1  reset, asynchronous and active-low.
REQ-004 Port: rx  input  1  serial line; idles high; one bit per CLK cycle.
REQ-005 Port: clear_err  input  1  synchronous clear of both sticky error flags.
REQ-006 Port: O_ready  input  1  consumer ready.
REQ-007 Port: O_data  output  8  head-of-FIFO byte.
REQ-008 Port: O_valid  output  1  FIFO non-empty.
REQ-009 Port: frame_err  output  1  sticky flag: a bad stop bit was seen.
REQ-010 Port: overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-011 Frame format (matches the upstream UART transmitter), one bit per cycle:
- start bit 0
- data bits 7 down to 0 (MSB first)
- stop bit 1
REQ-012 FSM states: IDLE, DATA, STOP, with a 3-bit down-counter idx.
REQ-013 IDLE transitions:
- rx==0 -> DATA, idx=7.
- rx==1 -> stay in IDLE.
REQ-014 DATA behaviour:
- Each cycle: shift[idx] = rx, then idx decrements.
- Cycle with idx==0: sample, then -> STOP.
- DATA lasts exactly 8 cycles.
REQ-015 STOP with rx==1: push shift into the FIFO, then -> IDLE.
REQ-016 STOP with rx==0:
- Set frame_err; discard the byte; -> IDLE.
- That 0 is not treated as a start bit.
REQ-017 A new start bit is accepted in the first IDLE cycle after STOP, so back-to-back 10-cycle frames are received without loss.
REQ-018 FIFO:
- DEPTH entries, registered storage.
- Pointer width log2(DEPTH)+1; pointers wrap modulo 2*DEPTH.
- full/empty derived from the pointers.
REQ-019 Pop occurs when O_valid && O_ready at a clock edge; O_data is combinational from the head entry.
REQ-020 Push latency: a byte pushed at STOP edge t is visible on O_data with O_valid=1 from cycle t+1.
REQ-021 Push when full without a same-cycle pop: byte dropped, overrun set, FIFO contents unchanged.
REQ-022 Push and pop in the same cycle (including when full): both take effect; occupancy unchanged; no overrun.
REQ-023 Pop when empty: ignored, since O_valid=0.
REQ-024 clear_err==1 clears both sticky flags next edge.
REQ-025 A set event in the same cycle as clear_err wins: the flag ends at 1.
REQ-026 O_data is held stable while O_valid=1 and O_ready=0.

Reset
REQ-027 ASYNCRESETN==0 immediately, independent of CLK:
- FSM=IDLE, idx=7, shift=0x00
- FIFO pointers=0
- O_valid=0, O_data=0x00
- frame_err=0, overrun=0
REQ-028 Reset asserted mid-frame abandons the partial byte; no push occurs.
REQ-029 After deassertion the first 0 on rx is treated as a start bit.
REQ-030 Release of ASYNCRESETN is synchronous to CLK; the first state update occurs on the first rising edge after release.

Verification
REQ-031 Single frame: rx=0,1,0,1,0,0,1,0,1,1 from cycle 0 (frame 0xA5) -> O_valid=1, O_data=0xA5 at cycle 10; frame_err=0.
REQ-032 Back-to-back 0x00 then 0xFF with O_ready=0 -> FIFO holds 2 entries; pops return 0x00 then 0xFF.
REQ-033 Framing error: frame 0x3C with stop bit 0 -> frame_err=1, O_valid stays 0; a following good frame 0x11 -> O_data=0x11, frame_err still 1 until clear_err pulse.
REQ-034 Overrun: DEPTH+1 frames 0x01..0x05 with O_ready=0 -> overrun=1; pops return 0x01..0x04; 0x05 is lost.
REQ-035 Full plus simultaneous pop: FIFO full, O_ready=1 on the STOP cycle of frame 0x77 -> overrun=0; 0x77 is retained last.
REQ-036 Reset mid-frame: ASYNCRESETN low after 4 data bits, then released with rx=1 -> no output byte; next frame 0x42 is received correctly.
